// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory arbiter.
//   arb_state_t : access sequencer states
//   arb_owner_t : which CPU port owns the current access
package mem_arb_pkg;

  localparam int ADDR_W = 8;   // word address into the 256-entry memory
  localparam int INST_W = 16;  // fetch word / memory word width
  localparam int DATA_W = 8;   // data-port byte width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port, memory port and
// stall/status signals around the arbiter.
//   slave  : arbiter side (takes requests + mem_rdata, drives acks/memory)
//   master : environment side (CPU ports + memory model)
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [INST_W-1:0] if_rdata;
  // data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_wdata;
  logic [INST_W-1:0] mem_rdata;
  // status
  logic              stall_if;
  logic              stall_dm;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_dm, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_dm, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 256x16 memory between the CPU fetch
// port (16-bit words) and data port (8-bit bytes). Each access runs
// IDLE -> ISSUE -> WAIT* -> ACK with fixed latency MEM_LAT; data wins ties
// unless it has already won STARVE_MAX grants in a row over a waiting fetch.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (request/ack ports, memory port, stalls, busy)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,  // 1..15
  parameter int STARVE_MAX = 2   // 1..15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT  = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam bit         HAS_WAIT   = (MEM_LAT > 1);

  arb_state_t        state_q,     state_d;
  arb_owner_t        owner_q,     owner_d;
  logic [3:0]        streak_q,    streak_d;
  logic [3:0]        wcnt_q,      wcnt_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] wbyte_q,     wbyte_d;
  logic              pick_if;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    wcnt_d     = wcnt_q;
    mem_en_d   = 1'b0;   // strobe only during ISSUE
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    wbyte_d    = wbyte_q;
    pick_if    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.dm_req || bus.if_req) begin
          // fetch wins only when alone or when data has hit its streak limit
          pick_if    = bus.if_req && (!bus.dm_req || (streak_q == STARVE_LIM));
          owner_d    = pick_if ? OWN_IF : OWN_DM;
          mem_addr_d = pick_if ? bus.if_addr : bus.dm_addr;
          mem_we_d   = !pick_if && bus.dm_we;
          wbyte_d    = pick_if ? '0 : bus.dm_wdata;
          mem_en_d   = 1'b1;
          if (!pick_if && bus.if_req)
            streak_d = (streak_q == STARVE_LIM) ? streak_q : streak_q + 4'd1;
          else
            streak_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = WAIT_INIT;
        state_d = HAS_WAIT ? WAIT : ACK;
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = ACK;
      end
      ACK: begin
        // requests are deliberately not sampled here
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_DM;
      streak_q   <= '0;
      wcnt_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wbyte_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      wcnt_q     <= wcnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wbyte_q    <= wbyte_d;
    end
  end

  // acks decode straight from state so an async reset kills them at once
  assign bus.if_ack    = (state_q == ACK) && (owner_q == OWN_IF);
  assign bus.dm_ack    = (state_q == ACK) && (owner_q == OWN_DM);
  assign bus.if_rdata  = bus.if_ack ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_ack ? bus.mem_rdata[DATA_W-1:0] : '0;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = {8'h00, wbyte_q};

  assign bus.stall_if  = bus.if_req && !bus.if_ack;
  assign bus.stall_dm  = bus.dm_req && !bus.dm_ack;
  assign bus.busy      = (state_q != IDLE);

endmodule
